// File: rtl/mem_axi_slave.sv
// AXI4 slave backed by a word-addressed memory: INCR bursts of 32-bit beats,
// independent read and write channels, each driven by its own small FSM.
module mem_axi_slave #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        S_AXI_CLK,
  input  logic        S_AXI_RSTN,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t r_state_reg, r_state_next;
  w_state_t w_state_reg, w_state_next;

  logic                  rst_done_reg;
  logic [DEPTH_LOG2-1:0] rd_idx_reg, wr_idx_reg;
  logic [7:0]            rd_cnt_reg, rd_len_reg, wr_cnt_reg, wr_len_reg;
  logic                  wr_err_reg;
  logic [1:0]            bresp_reg;
  logic [31:0]           rd_q_reg;

  logic                  ar_fire, r_fire, aw_fire, w_fire, b_fire;
  logic                  rd_last, wr_last, wlast_bad, rd_fetch;
  logic [DEPTH_LOG2-1:0] rd_fetch_idx;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, S_AXI_ARADDR[31:DEPTH_LOG2+2], S_AXI_ARADDR[1:0],
                              S_AXI_AWADDR[31:DEPTH_LOG2+2], S_AXI_AWADDR[1:0]};

  assign ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_fire  = S_AXI_RVALID  & S_AXI_RREADY;
  assign aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID  & S_AXI_WREADY;
  assign b_fire  = S_AXI_BVALID  & S_AXI_BREADY;

  assign rd_last   = (rd_cnt_reg == rd_len_reg);
  assign wr_last   = (wr_cnt_reg == wr_len_reg);
  assign wlast_bad = wr_last ? ~S_AXI_WLAST : S_AXI_WLAST;

  // The next word is fetched on AR acceptance and on every non-final R handshake.
  assign rd_fetch     = ar_fire | (r_fire & ~rd_last);
  assign rd_fetch_idx = ar_fire ? S_AXI_ARADDR[DEPTH_LOG2+1:2] : rd_idx_reg;

  // Ready outputs stay low until the first clock edge after reset release.
  always_ff @(posedge S_AXI_CLK or negedge S_AXI_RSTN) begin
    if (!S_AXI_RSTN) begin
      rst_done_reg <= 1'b0;
      r_state_reg  <= R_IDLE;
      w_state_reg  <= W_IDLE;
    end else begin
      rst_done_reg <= 1'b1;
      r_state_reg  <= r_state_next;
      w_state_reg  <= w_state_next;
    end
  end

  always_comb begin
    r_state_next  = r_state_reg;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        S_AXI_ARREADY = rst_done_reg;
        if (ar_fire) r_state_next = R_BURST;
      end
      R_BURST: begin
        S_AXI_RVALID = 1'b1;
        if (r_fire && rd_last) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_next  = w_state_reg;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        S_AXI_AWREADY = rst_done_reg;
        if (aw_fire) w_state_next = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (w_fire && wr_last) w_state_next = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (b_fire) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_CLK or negedge S_AXI_RSTN) begin
    if (!S_AXI_RSTN) begin
      rd_idx_reg <= '0;
      rd_cnt_reg <= '0;
      rd_len_reg <= '0;
      wr_idx_reg <= '0;
      wr_cnt_reg <= '0;
      wr_len_reg <= '0;
      wr_err_reg <= 1'b0;
      bresp_reg  <= 2'b00;
    end else begin
      if (rd_fetch) rd_idx_reg <= rd_fetch_idx + 1'b1;
      if (ar_fire) begin
        rd_cnt_reg <= '0;
        rd_len_reg <= S_AXI_ARLEN;
      end else if (r_fire && !rd_last) begin
        rd_cnt_reg <= rd_cnt_reg + 8'd1;
      end

      if (aw_fire) begin
        wr_idx_reg <= S_AXI_AWADDR[DEPTH_LOG2+1:2];
        wr_cnt_reg <= '0;
        wr_len_reg <= S_AXI_AWLEN;
        wr_err_reg <= 1'b0;
      end else if (w_fire) begin
        wr_idx_reg <= wr_idx_reg + 1'b1;
        wr_cnt_reg <= wr_cnt_reg + 8'd1;
        wr_err_reg <= wr_err_reg | wlast_bad;
        if (wr_last) bresp_reg <= (wr_err_reg | wlast_bad) ? 2'b10 : 2'b00;
      end
    end
  end

  // Memory contents survive reset; a same-cycle read sees the pre-write word.
  always_ff @(posedge S_AXI_CLK) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) mem[wr_idx_reg][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
    if (rd_fetch) rd_q_reg <= mem[rd_fetch_idx];
  end

  assign S_AXI_RDATA = S_AXI_RVALID ? rd_q_reg : 32'd0;
  assign S_AXI_RLAST = S_AXI_RVALID & rd_last;
  assign S_AXI_RRESP = 2'b00;
  assign S_AXI_BRESP = bresp_reg;

endmodule
